led_seq: RTL

Parametrised LED sequencer driving CHN active-low LED outputs from a prescaled step tick. It generalises the fixed three-colour rotating blinker with a configurable channel count and step period, four run modes (rotate, bounce, blink-all, hold), an enable, a step strobe and optional PWM dimming. It sits between the board clock and the LED pins, with mode and duty driven from control logic or tied off.

---
 rtl/led_seq_pkg.sv | 15 +
 rtl/led_seq_if.sv | 18 +
 rtl/led_seq_pwm_gen.sv | 25 ++
 rtl/led_seq.sv | 117 +++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: run-mode encodings and the idx width helper.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    function automatic int idx_width(input int chn);
        return (chn > 1) ? $clog2(chn) : 1;
    endfunction

endpackage

// File: rtl/led_seq_if.sv
// Control/status bundle of the LED sequencer; master = control logic, slave = sequencer.
interface led_seq_if #(
    parameter int CHN   = 3,
    parameter int PWM_W = 8
);
    localparam int IW = led_seq_pkg::idx_width(CHN);

    logic             en;
    logic [1:0]       mode;
    logic [PWM_W-1:0] duty;
    logic             step_tick;
    logic [IW-1:0]    idx;
    logic [CHN-1:0]   led_n;

    modport master (output en, mode, duty, input step_tick, idx, led_n);
    modport slave  (input en, mode, duty, output step_tick, idx, led_n);

endinterface

// File: rtl/led_seq_pwm_gen.sv
// PWM dimming generator, only built when LED_SEQ_PWM_EN is defined.
`ifdef LED_SEQ_PWM_EN
module pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_on
);
    logic [PWM_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // Full-scale duty must stay on through the counter's top value as well.
    assign pwm_on = (duty == '1) || (cnt < duty);

endmodule
`endif

// File: rtl/led_seq.sv
// Prescaled LED sequencer with rotate/bounce/blink/hold modes; LED_SEQ_PWM_EN adds PWM dimming.
module led_seq
    import led_seq_pkg::*;
#(
    parameter int CHN    = 3,
    parameter int PERIOD = 6000000,
    parameter int PWM_W  = 8
) (
    input logic       clk,
    input logic       rst,
    led_seq_if.slave  bus
);
    localparam int IW = idx_width(CHN);
    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0]  cnt;
    logic [CHN-1:0] pat;
    logic           dir;
    logic [CHN-1:0] pat_next;
    logic           dir_next;
    logic [IW-1:0]  idx_next;
    logic [CHN-1:0] up;
    logic [CHN-1:0] dn;
    logic           onehot;
    logic           onehot_next;
    logic           step;
    logic           pwm_on;

    assign step = bus.en && (cnt == CW'(PERIOD - 1));

`ifdef LED_SEQ_PWM_EN
    pwm_gen #(.PWM_W(PWM_W)) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .duty   (bus.duty),
        .pwm_on (pwm_on)
    );
`else
    logic unused_duty;
    assign unused_duty = ^bus.duty;
    assign pwm_on      = 1'b1;
`endif

    // Pattern that the next step would load; a non-one-hot pattern restarts rotate/bounce at bit 0.
    always_comb begin
        pat_next    = pat;
        dir_next    = dir;
        idx_next    = '0;
        up          = pat << 1;
        dn          = pat >> 1;
        onehot      = (pat != '0) && ((pat & (pat - CHN'(1))) == '0);
        case (mode_t'(bus.mode))
            MODE_ROTATE: begin
                if (!onehot) begin
                    pat_next = CHN'(1);
                    dir_next = 1'b0;
                end else begin
                    pat_next = up | (pat >> (CHN - 1));
                end
            end
            MODE_BOUNCE: begin
                if (!onehot) begin
                    pat_next = CHN'(1);
                    dir_next = 1'b0;
                end else if (CHN == 1) begin
                    pat_next = pat;
                end else if (!dir) begin
                    if (pat[CHN-1]) begin
                        pat_next = dn;
                        dir_next = 1'b1;
                    end else begin
                        pat_next = up;
                        dir_next = up[CHN-1];
                    end
                end else begin
                    if (pat[0]) begin
                        pat_next = up;
                        dir_next = 1'b0;
                    end else begin
                        pat_next = dn;
                        dir_next = ~dn[0];
                    end
                end
            end
            MODE_BLINK:  pat_next = (pat == '1) ? '0 : '1;
            default:     pat_next = pat;
        endcase
        onehot_next = (pat_next != '0) && ((pat_next & (pat_next - CHN'(1))) == '0);
        for (int i = 0; i < CHN; i++) begin
            if (onehot_next && pat_next[i])
                idx_next = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            pat           <= CHN'(1);
            dir           <= 1'b0;
            bus.step_tick <= 1'b0;
            bus.idx       <= '0;
            bus.led_n     <= '1;
        end else begin
            bus.step_tick <= step;
            bus.led_n     <= ~(pat & {CHN{pwm_on}});
            if (bus.en)
                cnt <= step ? '0 : cnt + 1'b1;
            if (step) begin
                pat     <= pat_next;
                dir     <= dir_next;
                bus.idx <= idx_next;
            end
        end
    end

endmodule
